// File: rtl/cfg_chain_bank.sv
// Multi-channel configuration-chain bank with shift counter, running CRC-8 (poly 0x07) and verify-then-lock FSM.
// Optional rotate-in-place readback of locked contents: define CFG_CHAIN_READBACK_EN.
module cfg_chain_bank #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 64,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                            prog_clk,
  input  logic                            pReset,
  input  logic                            Test_en,
  input  logic [NUM_CHAINS-1:0]           ccff_head,
  input  logic                            shift_en,
  input  logic                            unlock,
`ifdef CFG_CHAIN_READBACK_EN
  input  logic                            readback,
`endif
  input  logic [7:0]                      crc_ref,
  output logic [NUM_CHAINS-1:0]           ccff_tail,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_bits,
  output logic [CNT_W-1:0]                bit_count,
  output logic                            cfg_valid,
  output logic                            crc_err,
  output logic [1:0]                      state_dbg
);

  // shift_en is a qualifier, not a handshake: a shift is accepted on any
  // rising edge where shift_en=1 and the FSM is in IDLE or SHIFT.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       crc_q, crc_d, crc_seed, crc_fold;
  logic             err_q, err_d;
  logic             load_shift;
  logic             rotate;
  logic [CHAIN_LEN-1:0] chain_q [NUM_CHAINS];

  function automatic logic [7:0] fold_bits(input logic [7:0] c_in,
                                           input logic [NUM_CHAINS-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // A load started from IDLE restarts the CRC from zero.
  assign crc_seed = (state_q == IDLE) ? 8'h00 : crc_q;
  assign crc_fold = fold_bits(crc_seed, ccff_head);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    err_d      = err_q;
    load_shift = 1'b0;
    rotate     = 1'b0;
    if (!Test_en) begin
      case (state_q)
        IDLE: begin
          if (shift_en) begin
            load_shift = 1'b1;
            state_d    = SHIFT;
            cnt_d      = CNT_W'(1);
            crc_d      = crc_fold;
            err_d      = 1'b0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            load_shift = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            crc_d      = crc_fold;
            if (cnt_q == CNT_W'(CHAIN_LEN - 1)) state_d = CHECK;
          end
        end
        CHECK: begin
          if (crc_q == crc_ref) begin
            state_d = LOCKED;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        LOCKED: begin
          if (unlock) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
`ifdef CFG_CHAIN_READBACK_EN
          else if (readback && shift_en) begin
            rotate = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_chain
    always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
        chain_q[g] <= '0;
      end else if (Test_en || load_shift) begin
        chain_q[g] <= {chain_q[g][CHAIN_LEN-2:0], ccff_head[g]};
      end else if (rotate) begin
        chain_q[g] <= {chain_q[g][CHAIN_LEN-2:0], chain_q[g][CHAIN_LEN-1]};
      end
    end
    assign cfg_bits[g*CHAIN_LEN +: CHAIN_LEN] = chain_q[g];
    assign ccff_tail[g] = chain_q[g][CHAIN_LEN-1];
  end

  assign bit_count = cnt_q;
  assign cfg_valid = (state_q == LOCKED) && !Test_en;
  assign crc_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cfg_chain_bank.sv
// Directed bench for cfg_chain_bank with 4 chains of 8 bits.
module tb_cfg_chain_bank;

  localparam int NC = 4;
  localparam int CL = 8;
  localparam int CW = $clog2(CL + 1);

  // ---------------- clock / reset ----------------
  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b0;
  logic          Test_en  = 1'b0;
  logic [NC-1:0] ccff_head = '0;
  logic          shift_en = 1'b0;
  logic          unlock   = 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
  logic          readback = 1'b0;
`endif
  logic [7:0]    crc_ref  = 8'h00;
  logic [NC-1:0]    ccff_tail;
  logic [NC*CL-1:0] cfg_bits;
  logic [CW-1:0]    bit_count;
  logic             cfg_valid;
  logic             crc_err;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_CHECK = 2'd2, S_LOCKED = 2'd3;

  always #5 prog_clk = ~prog_clk;

  cfg_chain_bank #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .Test_en  (Test_en),
    .ccff_head(ccff_head),
    .shift_en (shift_en),
    .unlock   (unlock),
`ifdef CFG_CHAIN_READBACK_EN
    .readback (readback),
`endif
    .crc_ref  (crc_ref),
    .ccff_tail(ccff_tail),
    .cfg_bits (cfg_bits),
    .bit_count(bit_count),
    .cfg_valid(cfg_valid),
    .crc_err  (crc_err),
    .state_dbg(state_dbg)
  );

  // Byte-wise CRC-8/0x07 over the serial stream a constant head produces
  // for n shifts, chain 0 first within each shift.
  function automatic logic [7:0] golden_crc(input logic [NC-1:0] head, input int n);
    logic bits[$];
    logic [7:0] c, b;
    for (int s = 0; s < n; s++)
      for (int i = 0; i < NC; i++) bits.push_back(head[i]);
    c = 8'h00;
    for (int j = 0; j < bits.size() / 8; j++) begin
      for (int t = 0; t < 8; t++) b[7-t] = bits[8*j + t];
      c = c ^ b;
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic pulse_unlock();
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
  endtask

  task automatic full_load(input logic [NC-1:0] head, input logic [7:0] ref_crc);
    crc_ref   = ref_crc;
    ccff_head = head;
    shift_en  = 1'b1;
    repeat (CL) tick();
    shift_en  = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    repeat (10) tick();
    checks++; if (cfg_bits !== '0) begin errors++; $display("FAIL reset_cfg_bits got %h exp 0", cfg_bits); end
    checks++; if (ccff_tail !== '0) begin errors++; $display("FAIL reset_tail got %b exp 0", ccff_tail); end
    checks++; if (bit_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", bit_count); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cfg_valid); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_crc_err got %b exp 0", crc_err); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
  endtask

  task automatic test_lock_load();
    crc_ref   = golden_crc(4'b1010, CL);
    ccff_head = 4'b1010;
    shift_en  = 1'b1;
    repeat (CL) tick();
    shift_en  = 1'b0;
    checks++; if (bit_count !== CW'(CL)) begin errors++; $display("FAIL load_count got %0d exp %0d", bit_count, CL); end
    checks++; if (state_dbg !== S_CHECK) begin errors++; $display("FAIL load_check_state got %0d exp 2", state_dbg); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL load_valid_in_check got %b exp 0", cfg_valid); end
    tick();
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b exp 1", cfg_valid); end
    checks++; if (cfg_bits !== 32'hFF00FF00) begin errors++; $display("FAIL load_bits got %h exp ff00ff00", cfg_bits); end
    checks++; if (ccff_tail !== 4'b1010) begin errors++; $display("FAIL load_tail got %b exp 1010", ccff_tail); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL load_crc_err got %b exp 0", crc_err); end
  endtask

  task automatic test_crc_err();
    pulse_unlock();
    full_load(4'b1010, golden_crc(4'b1010, CL) ^ 8'h01);
    checks++; if (crc_err !== 1'b1) begin errors++; $display("FAIL crcerr_flag got %b exp 1", crc_err); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL crcerr_state got %0d exp 0", state_dbg); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL crcerr_valid got %b exp 0", cfg_valid); end
    checks++; if (cfg_bits !== 32'hFF00FF00) begin errors++; $display("FAIL crcerr_bits_kept got %h exp ff00ff00", cfg_bits); end
    crc_ref   = golden_crc(4'b1010, CL);
    shift_en  = 1'b1;
    tick();
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL crcerr_clear got %b exp 0", crc_err); end
    checks++; if (bit_count !== CW'(1)) begin errors++; $display("FAIL crcerr_first_count got %0d exp 1", bit_count); end
    repeat (CL - 1) tick();
    shift_en = 1'b0;
    tick();
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL crcerr_relock got %b exp 1", cfg_valid); end
  endtask

  task automatic test_lock_freeze();
    ccff_head = 4'b1111;
    shift_en  = 1'b1;
    repeat (5) tick();
    shift_en  = 1'b0;
    checks++; if (cfg_bits !== 32'hFF00FF00) begin errors++; $display("FAIL freeze_bits got %h exp ff00ff00", cfg_bits); end
    checks++; if (bit_count !== CW'(CL)) begin errors++; $display("FAIL freeze_count got %0d exp %0d", bit_count, CL); end
    pulse_unlock();
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL unlock_valid got %b exp 0", cfg_valid); end
    checks++; if (bit_count !== '0) begin errors++; $display("FAIL unlock_count got %0d exp 0", bit_count); end
    checks++; if (cfg_bits !== 32'hFF00FF00) begin errors++; $display("FAIL unlock_bits_kept got %h exp ff00ff00", cfg_bits); end
    // Reload with a pause and a stray unlock mid-load
    crc_ref   = golden_crc(4'b0101, CL);
    ccff_head = 4'b0101;
    shift_en  = 1'b1;
    repeat (4) tick();
    shift_en  = 1'b0;
    pulse_unlock();
    tick();
    checks++; if (bit_count !== CW'(4)) begin errors++; $display("FAIL gap_count got %0d exp 4", bit_count); end
    checks++; if (state_dbg !== S_SHIFT) begin errors++; $display("FAIL gap_state got %0d exp 1", state_dbg); end
    shift_en = 1'b1;
    repeat (4) tick();
    shift_en = 1'b0;
    tick();
    checks++; if (state_dbg !== S_LOCKED) begin errors++; $display("FAIL reload_state got %0d exp 3", state_dbg); end
    checks++; if (cfg_bits !== 32'h00FF00FF) begin errors++; $display("FAIL reload_bits got %h exp 00ff00ff", cfg_bits); end
  endtask

  task automatic test_reset_mid_load();
    pulse_unlock();
    ccff_head = 4'b1111;
    shift_en  = 1'b1;
    repeat (3) tick();
    #2;
    pReset = 1'b1;
    #1;
    checks++; if (cfg_bits !== '0) begin errors++; $display("FAIL midrst_bits got %h exp 0", cfg_bits); end
    checks++; if (ccff_tail !== '0) begin errors++; $display("FAIL midrst_tail got %b exp 0", ccff_tail); end
    checks++; if (bit_count !== '0) begin errors++; $display("FAIL midrst_count got %0d exp 0", bit_count); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL midrst_state got %0d exp 0", state_dbg); end
    shift_en = 1'b0;
    #1;
    pReset = 1'b0;
    full_load(4'b0011, golden_crc(4'b0011, CL));
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL midrst_relock got %b exp 1", cfg_valid); end
    checks++; if (cfg_bits !== 32'h0000FFFF) begin errors++; $display("FAIL midrst_bits_after got %h exp 0000ffff", cfg_bits); end
  endtask

  task automatic test_scan();
    Test_en   = 1'b1;
    ccff_head = 4'b0001;
    tick();
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL scan_valid got %b exp 0", cfg_valid); end
    repeat (CL - 1) tick();
    checks++; if (cfg_bits !== 32'h000000FF) begin errors++; $display("FAIL scan_bits got %h exp 000000ff", cfg_bits); end
    checks++; if (bit_count !== CW'(CL)) begin errors++; $display("FAIL scan_count got %0d exp %0d", bit_count, CL); end
    checks++; if (state_dbg !== S_LOCKED) begin errors++; $display("FAIL scan_state got %0d exp 3", state_dbg); end
    Test_en = 1'b0;
    #1;
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL scan_resume_valid got %b exp 1", cfg_valid); end
  endtask

`ifdef CFG_CHAIN_READBACK_EN
  task automatic test_readback();
    logic [CL-1:0]    m [NC];
    logic [NC*CL-1:0] orig, rot1;
    logic [NC-1:0]    h;
    for (int c = 0; c < NC; c++) m[c] = 8'hFF * (c == 0);
    Test_en = 1'b1;
    for (int s = 0; s < CL; s++) begin
      h = NC'(s) ^ 4'h5;
      ccff_head = h;
      tick();
      for (int c = 0; c < NC; c++) m[c] = {m[c][CL-2:0], h[c]};
    end
    Test_en = 1'b0;
    orig = {m[3], m[2], m[1], m[0]};
    for (int c = 0; c < NC; c++) m[c] = {m[c][CL-2:0], m[c][CL-1]};
    rot1 = {m[3], m[2], m[1], m[0]};
    readback = 1'b1;
    shift_en = 1'b1;
    tick();
    checks++; if (cfg_bits !== rot1) begin errors++; $display("FAIL rb_one_rot got %h exp %h", cfg_bits, rot1); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL rb_valid got %b exp 1", cfg_valid); end
    repeat (CL - 1) tick();
    readback = 1'b0;
    shift_en = 1'b0;
    checks++; if (cfg_bits !== orig) begin errors++; $display("FAIL rb_full got %h exp %h", cfg_bits, orig); end
    checks++; if (bit_count !== CW'(CL)) begin errors++; $display("FAIL rb_count got %0d exp %0d", bit_count, CL); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lock_load();
    test_crc_err();
    test_lock_freeze();
    test_reset_mid_load();
    test_scan();
`ifdef CFG_CHAIN_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cfg_chain_bank.md
Name: cfg_chain_bank

Overview:
- Parametrised, multi-channel configuration-chain bank: NUM_CHAINS parallel ccff shift chains of CHAIN_LEN bits each, feeding configuration bits to a tile.
- Adds what a single-chain tile lacks: a shift counter with a load/check/lock state machine, a running CRC-8 over all shifted bits, and a lock that freezes configuration once verified.
- Sits between the bitstream loader and tile configuration memory in the programming clock domain.

Parameters:
- NUM_CHAINS, 4, number of parallel chains (1..16)
- CHAIN_LEN, 64, bits per chain (2..1024)
- CNT_W, $clog2(CHAIN_LEN+1), shift-counter width (derived; do not override)

Ports:
- prog_clk  input  1  programming clock; all state on rising edge
- pReset  input  1  asynchronous, active-high reset
- Test_en  input  1  scan mode: shift on every cycle, bypass counter/FSM/lock
- ccff_head  input  NUM_CHAINS  serial data in, bit i to chain i
- shift_en  input  1  shift one bit into every chain this cycle
- unlock  input  1  single-cycle pulse: leave LOCKED
- crc_ref  input  8  expected CRC-8 of the full load
- ccff_tail  output  NUM_CHAINS  last bit of each chain
- cfg_bits  output  NUM_CHAINS*CHAIN_LEN  chain i occupies bits [i*CHAIN_LEN +: CHAIN_LEN]; bit 0 is head-side
- bit_count  output  CNT_W  shifts accepted in the current load
- cfg_valid  output  1  high in LOCKED only
- crc_err  output  1  sticky CRC-mismatch flag

Behaviour:
- Reset (pReset=1, asynchronous): all chain bits 0; crc=8'h00; bit_count=0; state=IDLE; cfg_valid=0; crc_err=0; ccff_tail=0.
- Shift: chain[i] <= {chain[i][CHAIN_LEN-2:0], ccff_head[i]}. ccff_tail[i] = chain[i][CHAIN_LEN-1], registered with zero extra latency.
- CRC-8, polynomial 0x07, MSB-first. Each accepted shift folds NUM_CHAINS bits, chain 0 first, combinationally in one cycle.
- FSM:
  - IDLE: shift_en -> SHIFT. This shift is accepted, bit_count=1, crc restarts from 8'h00 with this cycle's bits, crc_err cleared.
  - SHIFT: each shift_en increments bit_count. When the CHAIN_LEN-th shift is accepted -> CHECK. shift_en low holds state with no timeout.
  - CHECK (one cycle; shift_en ignored): crc==crc_ref -> LOCKED; else crc_err=1 -> IDLE. Chains retain contents either way.
  - LOCKED: cfg_valid=1. shift_en ignored and chains frozen. unlock -> IDLE, cfg_valid=0 next cycle, bit_count=0, contents kept.
- unlock outside LOCKED: no effect.
- Test_en=1: chains shift every cycle regardless of shift_en/state/lock. FSM, bit_count and crc hold. cfg_valid forced 0 combinationally. On Test_en falling, FSM resumes from its held state.
- pReset mid-load: immediate return to reset values; a partial load is discarded.
- bit_count never exceeds CHAIN_LEN and does not wrap.

Optional Feature:
- Macro CFG_CHAIN_READBACK_EN.
- Defined: adds input readback (1). In LOCKED with readback=1 and shift_en=1, every chain rotates (tail feeds head). CRC, bit_count and lock are untouched. After CHAIN_LEN rotations contents equal the original. cfg_valid stays 1 during rotation.
- Undefined: no readback port; LOCKED chains never move except under Test_en.

Test Plan:
- Reset then idle 10 cycles -> cfg_bits=0, ccff_tail=0, bit_count=0, cfg_valid=0, crc_err=0.
- NUM_CHAINS=4, CHAIN_LEN=8; shift 8 cycles with head=4'b1010 every cycle; crc_ref = golden model CRC -> bit_count=8, CHECK, then cfg_valid=1 one cycle later; chain1 and chain3 read 8'hFF, chain0 and chain2 read 8'h00.
- Same load with crc_ref XOR 8'h01 -> crc_err=1, state IDLE, cfg_valid=0. A new correct load clears crc_err on its first shift and locks.
- LOCKED, drive shift_en 5 cycles with head=4'b1111 -> cfg_bits unchanged. Pulse unlock -> cfg_valid=0 next cycle, then reload accepted.
- Assert pReset asynchronously after 3 of 8 shifts, mid-cycle -> all outputs zero before the next prog_clk edge; fresh 8-shift load locks normally.
- Test_en=1 for 8 cycles with head=4'b0001 -> chain0=8'hFF, others 0, cfg_valid=0, bit_count held. With CFG_CHAIN_READBACK_EN, 8 readback rotations in LOCKED -> cfg_bits unchanged.
